reg_dump_tx: RTL
================

// Module: reg_dump_tx
// PURPOSE
//  Debug stage downstream of the register file: on a start pulse, freezes the core
//  (activo=0), reads registers 0..N_REGS-1 one at a time through a 5-bit index into
//  the register-file debug mux, and streams each 32-bit value as 4 bytes, MSB first,
//  into the UART transmitter over a valid/ready byte handshake. Releases the core when done.
// PARAMETERS
//  N_REGS   32   number of registers dumped, 1..32, starting at index 0
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  inicio    in   1   synchronous active-high reset
//  start     in   1   dump request; sampled only in IDLE
//  dbg_data  in   32  register-file contents at index dbg_addr (combinational read)
//  dbg_addr  out  5   register index being read
//  tx_data   out  8   byte to UART transmitter
//  tx_valid  out  1   tx_data valid; held until accepted
//  tx_ready  in   1   UART can accept a byte this cycle
//  activo    out  1   core/register-file write enable; 0 while dumping
//  busy      out  1   1 in any state other than IDLE
//  done      out  1   one-cycle pulse at dump completion
// BEHAVIOUR
//  Reset (inicio=1 at posedge, any state): state=IDLE, dbg_addr=0, tx_data=0,
//   tx_valid=0, byte_cnt=0, activo=1, busy=0, done=0. inicio has priority over all inputs.
//  All outputs are registered or decoded from the state register only (Moore); no
//   combinational path from tx_ready/start/dbg_data to any output.
//  States: IDLE, LOAD, SEND, DONE.
//  IDLE: start=1 -> dbg_addr<=0, activo<=0, -> LOAD. start=0 -> stay.
//  LOAD: shift<=dbg_data, tx_data<=dbg_data[31:24], tx_valid<=1, byte_cnt<=0, -> SEND.
//   dbg_data is sampled one full cycle after dbg_addr changes and after activo=0,
//   so the register-file negedge write is already blocked; captured value is stable.
//  SEND: transfer occurs on a posedge with tx_valid=1 and tx_ready=1.
//   - no transfer: tx_valid, tx_data, byte_cnt held unchanged.
//   - transfer, byte_cnt<3: byte_cnt++, tx_data<=next byte (bits 23:16, 15:8, 7:0).
//   - transfer, byte_cnt==3: tx_valid<=0; if dbg_addr==N_REGS-1 -> DONE,
//     else dbg_addr<=dbg_addr+1 -> LOAD.
//  DONE: done=1 for this single cycle; activo<=1 -> IDLE.
//  start while not IDLE is ignored (no queuing). start=1 in the DONE cycle is ignored;
//   start held high continuously re-triggers from IDLE on the following cycle.
//  dbg_addr never exceeds N_REGS-1; no wrap. byte_cnt is 2 bits.
//  Throughput with tx_ready=1: 5 cycles/register (1 LOAD + 4 SEND).
//   start sampled at edge 0 -> first tx_valid after edge 1 -> last transfer at edge
//   5*N_REGS -> done high after edge 5*N_REGS, activo=1 after edge 5*N_REGS+1.
//  Reset mid-dump: stream aborts immediately, tx_valid drops, activo=1 next cycle;
//   a partially sent register is not resumed.
// TESTING
//  1 Reset: inicio=1 two cycles, random inputs -> activo=1, busy=0, tx_valid=0,
//    done=0, dbg_addr=0, tx_data=0.
//  2 Full dump, tx_ready=1, bank[i]=32'h11223300+i -> 128 bytes 11,22,33,00,11,22,33,01..
//    ..11,22,33,1F; done pulse after edge 160; activo low edges 1..161 exactly.
//  3 Backpressure: tx_ready random 30% high -> same byte stream, no byte duplicated or
//    dropped, tx_data/tx_valid stable while tx_valid=1 and tx_ready=0.
//  4 start pulsed again at register 7 of a dump -> ignored; exactly 128 bytes, one done.
//  5 inicio=1 while sending byte 2 of register 5 -> next cycle IDLE, tx_valid=0,
//    activo=1; a fresh start then dumps from register 0, byte 11.
//  6 N_REGS=1, bank[0]=32'hDEADBEEF, tx_ready=1 -> bytes DE,AD,BE,EF; done after edge 5.

Source files
------------

// File: rtl/reg_dump_tx_if.sv
// rtl/reg_dump_tx_if.sv - register-file debug read bus plus UART byte stream
interface reg_dump_tx_if;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // master: the dump engine; slave: register file mux + UART transmitter
    modport master (
        output dbg_addr,
        output tx_data,
        output tx_valid,
        input  dbg_data,
        input  tx_ready
    );

    modport slave (
        input  dbg_addr,
        input  tx_data,
        input  tx_valid,
        output dbg_data,
        output tx_ready
    );
endinterface

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - freezes the core and streams registers 0..N_REGS-1 MSB-first as bytes
module reg_dump_tx #(
    parameter int N_REGS = 32
) (
    input  logic                 clk,
    input  logic                 inicio,
    input  logic                 start,
    reg_dump_tx_if.master        bus,
    output logic                 activo,
    output logic                 busy,
    output logic                 done
);

    localparam logic [4:0] LAST_ADDR = 5'(N_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t      state_q,    state_d;
    logic [4:0]  dbg_addr_q, dbg_addr_d;
    logic [31:0] shift_q,    shift_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        activo_q,   activo_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    // Next-state logic: one register is captured in LOAD, then drained a byte per accepted transfer.
    always_comb begin
        state_d    = state_q;
        dbg_addr_d = dbg_addr_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        byte_cnt_d = byte_cnt_q;
        activo_d   = activo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dbg_addr_d = 5'd0;
                    activo_d   = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // activo has been low for a full cycle here, so dbg_data cannot change under us
                shift_d    = bus.dbg_data;
                tx_data_d  = bus.dbg_data[31:24];
                tx_valid_d = 1'b1;
                byte_cnt_d = 2'd0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    if (byte_cnt_q != 2'd3) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = shift_q[23:16];
                        shift_d    = shift_q << 8;
                    end else begin
                        tx_valid_d = 1'b0;
                        if (dbg_addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            dbg_addr_d = dbg_addr_q + 5'd1;
                            state_d    = ST_LOAD;
                        end
                    end
                end
            end
            ST_DONE: begin
                activo_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; inicio aborts any dump and releases the core.
    always_ff @(posedge clk) begin
        if (inicio) begin
            state_q    <= ST_IDLE;
            dbg_addr_q <= 5'd0;
            shift_q    <= 32'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            byte_cnt_q <= 2'd0;
            activo_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dbg_addr_q <= dbg_addr_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            byte_cnt_q <= byte_cnt_d;
            activo_q   <= activo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.dbg_addr = dbg_addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign activo       = activo_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
